// File: rtl/systemize_ctrl_pkg.sv
// rtl/systemize_ctrl_pkg.sv - shared types and constants for the systemizer sequencer
package systemize_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_L,
        ST_START_L,
        ST_WAIT_L,
        ST_REQ_R,
        ST_SKIP_R,
        ST_LOAD_R,
        ST_START_R,
        ST_WAIT_R,
        ST_READ,
        ST_FAIL
    } state_t;

    localparam logic [1:0] OP_FULL    = 2'b00;
    localparam logic [1:0] OP_LEFT    = 2'b01;
    localparam logic [1:0] OP_RIGHT   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Words in the whole matrix memory
    function automatic int words_total(input int l, input int k, input int n);
        return l * k / n;
    endfunction

    // Words in the left (square) block
    function automatic int words_left(input int l, input int n);
        return l * l / n;
    endfunction

endpackage

// File: rtl/sc_out_fifo.sv
// rtl/sc_out_fifo.sv - two-entry FIFO decoupling systemizer read latency from the output port
module sc_out_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Storage has no reset; emptiness is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/systemize_ctrl.sv
// rtl/systemize_ctrl.sv - load/start/readback sequencer for one systemizer instance
module systemize_ctrl
    import systemize_ctrl_pkg::*;
#(
    parameter int N  = 32,
    parameter int L  = 64,
    parameter int K  = 128,
    parameter int M  = 1,
    parameter int AW = $clog2(L * K / N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    output logic              busy,
    output logic              run_done,
    output logic              run_fail,
    output logic              src_restart,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [N*M-1:0]    src_data,
    input  logic [1:0]        sys_gen_left_op,
    input  logic [1:0]        sys_gen_right_op,
    output logic              sys_start,
    output logic              sys_start_right,
    input  logic              sys_done,
    input  logic              sys_success,
    input  logic              sys_fail,
    output logic              sys_wr_en,
    output logic [AW-1:0]     sys_wr_addr,
    output logic [N*M-1:0]    sys_data_in,
    output logic              sys_rd_en,
    output logic [AW-1:0]     sys_rd_addr,
    input  logic [N*M-1:0]    sys_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*M-1:0]    out_data
);

    localparam int DW = N * M;
    localparam int WT = words_total(L, K, N);
    localparam int WL = words_left(L, N);
    localparam logic [AW-1:0] LAST_T = AW'(WT - 1);
    localparam logic [AW-1:0] LAST_L = AW'(WL - 1);
    localparam logic [AW:0]   WT_CNT = (AW + 1)'(WT);

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   last_addr;
    logic [AW:0]     rd_cnt;
    logic [AW-1:0]   out_cnt;
    logic            rd_inflight;
    logic            done_q;
    logic [1:0]      fifo_count;
    logic [DW-1:0]   fifo_head;
    logic            src_fire;
    logic            pop;
    logic            left_legal;

    assign src_fire    = src_valid && src_ready;
    assign left_legal  = (sys_gen_left_op == OP_FULL) || (sys_gen_left_op == OP_LEFT);
    assign busy        = (state != ST_IDLE);
    assign run_done    = done_q;
    assign sys_wr_en   = src_fire && ((state == ST_LOAD_L) || (state == ST_LOAD_R));
    assign sys_wr_addr = addr;
    assign sys_data_in = sys_wr_en ? src_data : '0;
    assign out_valid   = (fifo_count != 2'd0);
    assign out_data    = out_valid ? fifo_head : '0;
    assign pop         = out_valid && out_ready;
    assign sys_rd_addr = rd_cnt[AW-1:0];
    // A new read only when the FIFO can still hold every word already requested
    assign sys_rd_en   = (state == ST_READ) && (rd_cnt != WT_CNT)
                         && (({1'b0, fifo_count} + {2'b00, rd_inflight}) < 3'd2);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and single-cycle control pulses
    always_comb begin
        state_nx        = state;
        src_ready       = 1'b0;
        src_restart     = 1'b0;
        sys_start       = 1'b0;
        sys_start_right = 1'b0;
        run_fail        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    src_restart = 1'b1;
                    state_nx    = left_legal ? ST_LOAD_L : ST_FAIL;
                end
            end
            ST_LOAD_L: begin
                src_ready = 1'b1;
                if (src_valid && (addr == last_addr)) begin
                    state_nx = ST_START_L;
                end
            end
            ST_START_L: begin
                sys_start = 1'b1;
                state_nx  = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (sys_fail) begin
                    state_nx = ST_FAIL;
                end else if (sys_success) begin
                    state_nx = ST_REQ_R;
                end else if (sys_done) begin
                    state_nx = ST_READ;
                end
            end
            ST_REQ_R: begin
                src_restart = 1'b1;
                case (sys_gen_right_op)
                    OP_ILLEGAL: state_nx = ST_FAIL;
                    OP_RIGHT:   state_nx = ST_SKIP_R;
                    default:    state_nx = ST_LOAD_R;
                endcase
            end
            ST_SKIP_R: begin
                src_ready = 1'b1;
                if (src_valid && (addr == LAST_L)) begin
                    state_nx = ST_LOAD_R;
                end
            end
            ST_LOAD_R: begin
                src_ready = 1'b1;
                if (src_valid && (addr == last_addr)) begin
                    state_nx = ST_START_R;
                end
            end
            ST_START_R: begin
                sys_start_right = 1'b1;
                state_nx        = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (sys_done) begin
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                if (pop && (out_cnt == LAST_T)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FAIL: begin
                run_fail = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address counters; the skip phase counts 0..WL-1 so the right load starts at WL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr        <= '0;
            last_addr   <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            rd_inflight <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= (state == ST_READ) && pop && (out_cnt == LAST_T);
            rd_inflight <= sys_rd_en;
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        addr      <= '0;
                        last_addr <= (sys_gen_left_op == OP_LEFT) ? LAST_L : LAST_T;
                    end
                end
                ST_LOAD_L, ST_SKIP_R, ST_LOAD_R: begin
                    if (src_fire) begin
                        addr <= addr + 1'b1;
                    end
                end
                ST_REQ_R: begin
                    addr      <= '0;
                    last_addr <= (sys_gen_right_op == OP_LEFT) ? LAST_L : LAST_T;
                end
                default: ;
            endcase
            if (state == ST_READ) begin
                if (sys_rd_en) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end else begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end
        end
    end

    sc_out_fifo #(
        .W (DW)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight),
        .push_data (sys_data_out),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_systemize_ctrl.sv
// tb/tb_systemize_ctrl.sv - randomized self-checking bench for systemize_ctrl
module tb_systemize_ctrl;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int K  = 16;
    localparam int M  = 1;
    localparam int DW = 4;
    localparam int AW = 5;
    localparam int WT = 32;
    localparam int WL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          busy, run_done, run_fail, src_restart;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] src_data;
    logic [1:0]    sys_gen_left_op = 2'b00;
    logic [1:0]    sys_gen_right_op = 2'b00;
    logic          sys_start, sys_start_right;
    logic          sys_done = 1'b0;
    logic          sys_success = 1'b0;
    logic          sys_fail = 1'b0;
    logic          sys_wr_en;
    logic [AW-1:0] sys_wr_addr;
    logic [DW-1:0] sys_data_in;
    logic          sys_rd_en;
    logic [AW-1:0] sys_rd_addr;
    logic [DW-1:0] sys_data_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    systemize_ctrl #(.N(N), .L(L), .K(K), .M(M), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .busy(busy),
        .run_done(run_done), .run_fail(run_fail), .src_restart(src_restart),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .sys_gen_left_op(sys_gen_left_op), .sys_gen_right_op(sys_gen_right_op),
        .sys_start(sys_start), .sys_start_right(sys_start_right),
        .sys_done(sys_done), .sys_success(sys_success), .sys_fail(sys_fail),
        .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in),
        .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Environment: generator stream and systemizer memory
    logic [DW-1:0] gen [64];
    logic [DW-1:0] init_mem [WT];
    logic [DW-1:0] sysmem [WT];
    int            wr_epoch [WT];
    int            epoch = 0;
    int            gen_idx = 0;

    assign src_data = gen[gen_idx[5:0]];

    always @(posedge clk) begin
        if (!rst_n) gen_idx <= 0;
        else if (src_restart) gen_idx <= 0;
        else if (src_valid && src_ready) gen_idx <= gen_idx + 1;
        if (sys_wr_en) begin
            sysmem[sys_wr_addr]   <= sys_data_in;
            wr_epoch[sys_wr_addr] <= epoch;
        end
        if (sys_rd_en)
            sys_data_out <= (wr_epoch[sys_rd_addr] == epoch) ? sysmem[sys_rd_addr] : init_mem[sys_rd_addr];
    end

    // Source-valid and sink-ready pattern generators
    int vmode = 0;
    int rmode = 0;
    int ready_ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                0: src_valid = 1'b1;
                1: src_valid = ~src_valid;
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            ready_ph++;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference expectations
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          right;
    } wr_t;

    wr_t           exp_wr_q [$];
    logic [DW-1:0] exp_out_q [$];

    int obs_start = 0, obs_start_r = 0, obs_restart = 0, obs_done = 0, obs_fail = 0;
    int obs_wr = 0, obs_pop = 0;
    bit last_prev = 0, right_prev = 0, pop_last_prev = 0, fail_prev = 0;
    int outstanding = 0;
    int exp_rd = 0;
    wr_t e;
    logic [DW-1:0] d;

    // Per-cycle compare against the expectation queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_prev = 0; right_prev = 0; pop_last_prev = 0; fail_prev = 0;
                outstanding = 0; exp_rd = 0;
            end else begin
                check("start_l_timing", sys_start, last_prev && !right_prev);
                check("start_r_timing", sys_start_right, last_prev && right_prev);
                check("run_done_timing", run_done, pop_last_prev);
                if (fail_prev) check("idle_after_fail", busy, 1'b0);
                last_prev = 0;
                pop_last_prev = 0;
                if (sys_wr_en) begin
                    obs_wr++;
                    if (exp_wr_q.size() == 0) check("wr_expected", 1'b1, 1'b0);
                    else begin
                        e = exp_wr_q.pop_front();
                        check("wr_addr", sys_wr_addr, e.addr);
                        check("wr_data", sys_data_in, e.data);
                        last_prev = e.last;
                        right_prev = e.right;
                    end
                end
                if (sys_rd_en) begin
                    check("rd_room", outstanding < 2, 1'b1);
                    check("rd_addr", sys_rd_addr, exp_rd[AW-1:0]);
                    exp_rd++;
                    outstanding++;
                end
                if (out_valid) check("out_valid_expected", exp_out_q.size() != 0, 1'b1);
                if (out_valid && out_ready) begin
                    obs_pop++;
                    outstanding--;
                    if (exp_out_q.size() != 0) begin
                        d = exp_out_q.pop_front();
                        check("out_data", out_data, d);
                        pop_last_prev = (exp_out_q.size() == 0);
                    end
                end
                if (sys_start) obs_start++;
                if (sys_start_right) obs_start_r++;
                if (src_restart) obs_restart++;
                if (run_done) obs_done++;
                if (run_fail) obs_fail++;
                fail_prev = run_fail;
                if (!busy) begin
                    exp_rd = 0;
                    outstanding = 0;
                end
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        exp_wr_q.delete();
        exp_out_q.delete();
    endtask

    task automatic wait_count(input string name, ref int cnt, input int base);
        int t;
        t = 0;
        while (cnt == base && t < 400) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 400) check(name, 1'b0, 1'b1);
    endtask

    task automatic run_case(input logic [1:0] lop, input logic [1:0] rop, input int stat,
                            input int vm, input int rm, input bit abort,
                            input int exp_wr_n, input int exp_pop_n);
        logic [DW-1:0] em [WT];
        bit left_ok, right_ok, fail_exp, startr_exp, done_exp;
        int nl, lo, hi, t;
        int b_wr, b_pop, b_st, b_sr, b_rs, b_done, b_fail;
        left_ok    = (lop != 2'b11);
        right_ok   = (rop != 2'b11);
        fail_exp   = !left_ok || stat == 2 || (stat == 1 && !right_ok);
        startr_exp = left_ok && stat == 1 && right_ok;
        done_exp   = !fail_exp && !abort;
        vmode = vm;
        rmode = rm;
        epoch++;
        for (int i = 0; i < 64; i++) gen[i] = DW'($urandom);
        for (int a = 0; a < WT; a++) begin
            init_mem[a] = DW'($urandom);
            em[a] = init_mem[a];
        end
        if (left_ok) begin
            nl = (lop == 2'b01) ? WL : WT;
            for (int a = 0; a < nl; a++) begin
                exp_wr_q.push_back('{AW'(a), gen[a], (a == nl - 1), 1'b0});
                em[a] = gen[a];
            end
        end
        if (startr_exp) begin
            lo = (rop == 2'b10) ? WL : 0;
            hi = (rop == 2'b01) ? WL : WT;
            for (int a = lo; a < hi; a++) begin
                exp_wr_q.push_back('{AW'(a), gen[a], (a == hi - 1), 1'b1});
                em[a] = gen[a];
            end
        end
        if (done_exp) for (int a = 0; a < WT; a++) exp_out_q.push_back(em[a]);
        b_wr = obs_wr; b_pop = obs_pop; b_st = obs_start; b_sr = obs_start_r;
        b_rs = obs_restart; b_done = obs_done; b_fail = obs_fail;

        @(posedge clk); #1;
        cmd_start = 1'b1; sys_gen_left_op = lop; sys_gen_right_op = rop;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        sys_gen_left_op = ~lop;
        if (left_ok) begin
            wait_count("timeout_start", obs_start, b_st);
            repeat (4) @(posedge clk);
            #1;
            if (stat == 2) begin sys_fail = 1'b1; sys_success = 1'b1; end
            else if (stat == 1) sys_success = 1'b1;
            else sys_done = 1'b1;
            @(posedge clk); #1;
            sys_fail = 1'b0; sys_success = 1'b0; sys_done = 1'b0;
            if (startr_exp) begin
                wait_count("timeout_start_r", obs_start_r, b_sr);
                repeat (3) @(posedge clk);
                #1;
                if (abort) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    check("abort_outputs_zero",
                          {busy, run_done, run_fail, src_restart, src_ready, sys_start,
                           sys_start_right, sys_wr_en, sys_rd_en, out_valid, sys_wr_addr,
                           sys_rd_addr, sys_data_in, out_data}, 64'd0);
                    rst_n = 1'b1;
                end else begin
                    sys_done = 1'b1;
                    @(posedge clk); #1;
                    sys_done = 1'b0;
                end
            end
        end
        if (!abort) begin
            t = 0;
            while (obs_done == b_done && obs_fail == b_fail && t < 2000) begin
                @(posedge clk); #1; t++;
            end
            if (t >= 2000) begin
                check("timeout_end", 1'b0, 1'b1);
                pulse_reset();
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("n_start", obs_start - b_st, left_ok);
        check("n_start_right", obs_start_r - b_sr, startr_exp);
        check("n_restart", obs_restart - b_rs, 1 + (left_ok && stat == 1));
        check("n_done", obs_done - b_done, done_exp);
        check("n_fail", obs_fail - b_fail, fail_exp);
        check("n_writes", obs_wr - b_wr, exp_wr_n);
        check("n_outputs", obs_pop - b_pop, exp_pop_n);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("out_queue_drained", exp_out_q.size(), 0);
        check("idle_at_end", busy, 1'b0);
        exp_wr_q.delete();
        exp_out_q.delete();
    endtask

    initial begin
        int lop, rop, st, nw, np;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero",
              {busy, run_done, run_fail, src_restart, src_ready, sys_start,
               sys_start_right, sys_wr_en, sys_rd_en, out_valid, sys_wr_addr,
               sys_rd_addr, sys_data_in, out_data}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_case(2'b00, 2'b00, 0, 0, 0, 1'b0, 32, 32);
        run_case(2'b01, 2'b10, 1, 0, 0, 1'b0, 32, 32);
        run_case(2'b00, 2'b00, 2, 0, 0, 1'b0, 32, 0);
        run_case(2'b00, 2'b00, 0, 0, 1, 1'b0, 32, 32);
        run_case(2'b00, 2'b00, 0, 1, 0, 1'b0, 32, 32);
        run_case(2'b01, 2'b00, 1, 0, 0, 1'b1, 48, 0);
        run_case(2'b00, 2'b00, 0, 0, 0, 1'b0, 32, 32);
        run_case(2'b11, 2'b00, 0, 0, 0, 1'b0, 0, 0);
        run_case(2'b01, 2'b11, 1, 0, 0, 1'b0, 16, 0);
        run_case(2'b01, 2'b01, 1, 2, 2, 1'b0, 32, 32);

        for (int r = 0; r < 6; r++) begin
            lop = $urandom_range(0, 1);
            rop = $urandom_range(0, 2);
            st  = $urandom_range(0, 2);
            nw  = (lop == 1) ? WL : WT;
            if (st == 1) nw += (rop == 0) ? WT : WL;
            np  = (st == 2) ? 0 : WT;
            run_case(2'(lop), 2'(rop), st, 2, 2, 1'b0, nw, np);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
